// File: rtl/div_unit_if.sv
// ============================================================================
//  Module      : div_unit_if
//  Description : Handshake and operand/result bundle for the iterative
//                divider. The pipeline side is the master; the divider is
//                the slave.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_unit_if;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  Module      : div_unit
//  Description : 32-bit signed/unsigned restoring divider, one quotient bit
//                per clock. Produces {remainder, quotient} with a one-cycle
//                ready pulse; divide-by-zero short-circuits to a zero result.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit (
  input  wire logic   clk,
  input  wire logic   rst,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  localparam logic [5:0] C_LAST_STEP = 6'd32;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // [64:32] partial remainder, [31:0] dividend bits shifting out / quotient bits shifting in
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  // Signed mode is folded into these two flags at launch time
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic [31:0] w_mag1, w_mag2;
  logic [64:0] w_shifted;
  logic [32:0] w_diff;
  logic [64:0] w_step;
  logic [31:0] w_quot, w_rem;

  // Operand magnitudes; 0x80000000 negates to itself and is read as unsigned
  always_comb begin
    w_mag1 = (bus.signed_i && bus.opdata1_i[31]) ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
    w_mag2 = (bus.signed_i && bus.opdata2_i[31]) ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;
  end

  // One restoring shift-subtract step and the final sign correction
  always_comb begin
    w_shifted = {work_q[63:0], 1'b0};
    w_diff    = w_shifted[64:32] - {1'b0, divisor_q};
    if (!w_diff[32]) begin
      w_step = {w_diff, w_shifted[31:1], 1'b1};
    end else begin
      w_step = w_shifted;
    end
    w_quot = neg_quot_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
    w_rem  = neg_rem_q  ? (32'd0 - work_q[63:32]) : work_q[63:32];
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          cnt_d = 6'd0;
          if (bus.opdata2_i == 32'd0) begin
            state_d = S_DIVZERO;
          end else begin
            state_d    = S_ON;
            work_d     = {33'd0, w_mag1};
            divisor_d  = w_mag2;
            neg_quot_d = bus.signed_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_rem_d  = bus.signed_i & bus.opdata1_i[31];
          end
        end
      end
      S_DIVZERO: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = 64'd0;
        end
      end
      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == C_LAST_STEP) begin
          state_d  = S_END;
          result_d = {w_rem, w_quot};
        end else begin
          work_d = w_step;
          cnt_d  = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_END);
  end

  // State and output registers; reset forces the idle state immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      work_q     <= 65'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;

endmodule

`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits and the result width at 64 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; it SHALL force the block to its reset state immediately while low.
REQ-004 start_i  input  1  request a division; sampled only in IDLE.
REQ-005 signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); latched with start_i.
REQ-006 annul_i  input  1  flush request; cancels any operation in progress.
REQ-007 opdata1_i  input  32  dividend; latched with start_i.
REQ-008 opdata2_i  input  32  divisor; latched with start_i.
REQ-009 result_o  output  64  [63:32] = remainder (destined for HI), [31:0] = quotient (destined for LO).
REQ-010 ready_o  output  1  one-cycle pulse; result_o is valid and is the HI/LO write strobe for both halves.
REQ-011 busy_o  output  1  high in DIVZERO, ON and END; the pipeline stalls on it.

Function
REQ-012 States SHALL be IDLE, DIVZERO, ON and END, encoded in 2 bits.
REQ-013 IDLE SHALL move to DIVZERO when start_i=1, annul_i=0 and opdata2_i=0.
REQ-014 IDLE SHALL move to ON when start_i=1, annul_i=0 and opdata2_i!=0.
- In the same edge, the block SHALL latch signed_i and the operands.
- The 6-bit step counter SHALL be cleared.
REQ-015 In signed mode the block SHALL divide the magnitudes of the latched operands (two's-complement negate if negative).
- Magnitude of 0x80000000 = 0x80000000, treated as unsigned.
REQ-016 ON SHALL perform one restoring shift-subtract step per edge on a 65-bit working register, 32 steps in total.
REQ-017 After the 32nd step the block SHALL apply sign correction and move to END.
- Signed: quotient negated if the operand signs differ; remainder negated if the dividend is negative.
- Unsigned: no correction.
REQ-018 Latency: with start_i sampled at edge N, result_o SHALL update and ready_o SHALL be high from edge N+33 to edge N+34.
REQ-019 DIVZERO SHALL move to END at the next edge and set result_o = 0; ready_o SHALL be high from edge N+1 to N+2.
REQ-020 END SHALL return to IDLE on the next edge unconditionally; ready_o SHALL be high only in END.
REQ-021 A new start_i SHALL be accepted in the IDLE cycle immediately following END.
REQ-022 start_i SHALL be ignored in DIVZERO, ON and END.
REQ-023 annul_i=1 in DIVZERO or ON SHALL return the block to IDLE at the next edge.
- ready_o SHALL NOT pulse.
- result_o SHALL keep its previous value.
REQ-024 annul_i=1 in END SHALL NOT suppress the ready_o pulse already in progress.
REQ-025 start_i=1 and annul_i=1 together in IDLE SHALL NOT start an operation.
REQ-026 result_o SHALL hold its last value between operations and change only on the edge entering END.
REQ-027 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-028 All arithmetic SHALL be modulo 2^32 per half; there SHALL be no exception output.

Reset
REQ-029 While rst=0 the block SHALL hold the following values, regardless of clk:
- state = IDLE, counter = 0
- result_o = 0
- ready_o = 0, busy_o = 0
REQ-030 Reset asserted mid-operation SHALL abort the division with no ready_o pulse.
REQ-031 After rst rises, the first start_i SHALL be accepted at the first rising edge.

Verification
REQ-032 Unsigned 100 / 7, start at edge N -> ready_o high after N+33 for one cycle; result_o = {0x00000002, 0x0000000E}; busy_o high N..N+34.
REQ-033 Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
REQ-034 Divisor 0 (0x1234 / 0) -> ready_o high after N+1 only; result_o = 0.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> result_o = {0x00000000, 0x80000000}; unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
REQ-036 Annul at edge N+10 of a running division -> no ready_o pulse, busy_o low after N+11, result_o unchanged.
- A start_i at N+11 SHALL be accepted normally.
REQ-037 Reset cases:
- rst low at N+5 -> outputs immediately at reset values.
- start_i held high during reset -> no operation begins until rst high.
